// File: rtl/bin2bcd_param.sv
// Sequential double-dabble binary-to-BCD converter with leading-zero
// blanking mask and overflow flag for results wider than DIGITS digits.
module bin2bcd_param #(
    parameter int BIN_WIDTH = 10,
    parameter int DIGITS    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [BIN_WIDTH-1:0]  i_bin,
    output logic                  o_ready,
    output logic                  o_done_tick,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic [DIGITS-1:0]     o_blank,
    output logic                  o_overflow
);

    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OP,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [BIN_WIDTH-1:0]   r_sh;
    logic [BIN_WIDTH-1:0]   w_sh_next;
    logic [BIN_WIDTH-1:0]   w_sh_shift;
    logic [4*DIGITS-1:0]    r_dig;
    logic [4*DIGITS-1:0]    w_dig_adj;
    logic [4*DIGITS-1:0]    w_dig_shift;
    logic [4*DIGITS-1:0]    w_dig_next;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_next;
    logic                   r_ovf;
    logic                   w_ovf_next;
    logic                   w_top;
    logic                   w_load_out;
    logic [DIGITS-1:0]      w_blank_next;
    logic [4*DIGITS-1:0]    r_bcd;
    logic [DIGITS-1:0]      r_blank;
    logic                   r_overflow;

    // Add-3 correction on every digit that would reach 10 after doubling
    always_comb begin
        w_dig_adj = r_dig;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_dig[4*i +: 4] >= 4'd5) begin
                w_dig_adj[4*i +: 4] = r_dig[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_top       = w_dig_adj[4*DIGITS-1];
    assign w_dig_shift = {w_dig_adj[4*DIGITS-2:0], r_sh[BIN_WIDTH-1]};
    assign w_sh_shift  = r_sh << 1;

    always_comb begin
        logic v_zero;
        v_zero       = 1'b1;
        w_blank_next = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            v_zero          = v_zero & (w_dig_shift[4*i +: 4] == 4'd0);
            w_blank_next[i] = v_zero;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sh_next    = r_sh;
        w_dig_next   = r_dig;
        w_cnt_next   = r_cnt;
        w_ovf_next   = r_ovf;
        w_load_out   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_sh_next    = i_bin;
                    w_dig_next   = '0;
                    w_cnt_next   = CW'(BIN_WIDTH);
                    w_ovf_next   = 1'b0;
                    w_state_next = S_OP;
                end
            end
            S_OP: begin
                w_sh_next  = w_sh_shift;
                w_dig_next = w_dig_shift;
                w_cnt_next = r_cnt - CW'(1);
                w_ovf_next = r_ovf | w_top;
                if (r_cnt == CW'(1)) begin
                    w_state_next = S_DONE;
                    w_load_out   = 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_sh       <= '0;
            r_dig      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_bcd      <= '0;
            r_blank    <= BLANK_RST;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sh    <= w_sh_next;
            r_dig   <= w_dig_next;
            r_cnt   <= w_cnt_next;
            r_ovf   <= w_ovf_next;
            // Results change only on the edge that enters DONE
            if (w_load_out) begin
                r_bcd      <= w_dig_shift;
                r_blank    <= w_blank_next;
                r_overflow <= r_ovf | w_top;
            end
        end
    end

    assign o_ready     = (r_state == S_IDLE);
    assign o_done_tick = (r_state == S_DONE);
    assign o_bcd       = r_bcd;
    assign o_blank     = r_blank;
    assign o_overflow  = r_overflow;

endmodule
